permutation_controller: RTL and testbench
=========================================

Name: permutation_controller

Overview:
- Sequencing FSM for the permutation datapath (input mux, matrix register, mapper, mod-Count round counter).
- Accepts one matrix job per valid/ready handshake and loads it into the matrix register.
- Applies the mapper for exactly Count rounds using the round counter's carry-out.
- Then presents the result with a valid/ready output handshake held until consumed.

Parameters:
- Count, 64, number of mapper rounds per job; must equal the datapath counter's Count; legal range Count >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- inValid  input  1  upstream has a matrix on the datapath matrixIn bus.
- inReady  output  1  controller can accept a job this cycle.
- outValid  output  1  datapath matrixOut holds a finished result.
- outReady  input  1  downstream consumes the result this cycle.
- busy  output  1  a job is in flight (ROUND or DONE).
- cntCo  input  1  datapath counter carry; high whenever counter value == Count-1, independent of its enable.
- ldReg  output  1  matrix register load.
- selRes  output  1  mux select: 0 = matrixIn, 1 = mapper output.
- cntEn  output  1  counter increment enable.
- cntClr  output  1  counter synchronous clear.

Behaviour:
- States: IDLE, ROUND, DONE; 2-bit encoding.
- Reset (rst low) forces IDLE immediately. While rst is low, every output is 0, including inReady, which is gated by rst. The counter itself is reset by the datapath.
- Accept condition: acc = inValid & inReady.
- inReady = rst & ((state==IDLE) | (state==DONE & outReady)).
- On acc (Mealy, same cycle):
  - ldReg=1, selRes=0, cntClr=1, cntEn=0.
  - matrixIn needs to be valid only in this cycle.
  - Next state is ROUND.
- ROUND (Moore):
  - ldReg=1, selRes=1, cntEn=1, cntClr=0.
  - Each cycle registers one mapper application.
  - If cntCo=1, this cycle is the Count-th round; next state is DONE.
  - Otherwise stay in ROUND.
- DONE:
  - outValid=1; ldReg=0, cntEn=0; matrixOut is stable.
  - outReady=1 with inValid=0: go to IDLE.
  - outReady=1 with inValid=1 (back-to-back): result consumed and new job accepted in the same cycle (load outputs as for acc); next state is ROUND.
  - outReady=0: hold DONE; inReady=0; no datapath controls asserted.
- IDLE: all datapath controls 0 unless acc.
- busy = (state==ROUND) | (state==DONE).
- Latency:
  - Handshake at edge T loads the register.
  - Rounds are registered at edges T+1 .. T+Count.
  - outValid is high from the cycle after edge T+Count.
  - Handshake-to-result is Count+1 cycles.
- The counter is cleared at every accept, so a stale counter value never affects round count.
- cntCo observed in IDLE or DONE is ignored.
- Reset mid-ROUND or mid-DONE:
  - Job abandoned; outValid drops asynchronously; no partial result is flagged.
  - After release the controller is in IDLE with inReady=1.
- inValid or outReady with X/unknown timing outside a handshake has no effect.
- No state is reachable outside IDLE/ROUND/DONE; the unused encoding decodes to IDLE.

Decomposition:
- Shared header permutation_defs.v holds:
  - state encodings S_IDLE=2'd0, S_ROUND=2'd1, S_DONE=2'd2;
  - default round Count 64, used by both datapath and controller.
- No sub-module. This is a single FSM: one state register with async active-low reset, next-state logic, and output decode.
- The top-level wrapper instantiating controller and datapath is a separate block.

Test Plan:
- Basic job: rst low 3 cycles, release; inValid=1 one cycle with matrixIn=25'h0000001; outReady=1 → ldReg/cntClr pulse at accept, exactly 64 cycles of ldReg=selRes=cntEn=1, outValid high at cycle 65 for one cycle, matrixOut equals the golden 64-fold mapper result.
- Backpressure: as above with outReady=0 for 10 cycles after outValid → outValid and matrixOut held constant, inReady=0, cntEn=0, then IDLE one cycle after outReady=1.
- Back-to-back: second inValid asserted in the DONE cycle with outReady=1 → new load the same cycle with no idle bubble; second result 65 cycles later.
- Reset mid-run: drop rst at round 30 → outValid, ldReg and busy go 0 asynchronously; after release a new job completes in 65 cycles with the correct result.
- Idle immunity: inValid=0 for 100 cycles → no ldReg/cntEn activity; inReady=1, busy=0.
- Count=4 build: job completes with exactly 4 round loads; outValid at handshake+5.

Source files
------------

// File: rtl/permutation_controller_pkg.sv
// permutation_controller_pkg: state encoding and default round count shared by controller and datapath
package permutation_controller_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;
    localparam int unsigned DEFAULT_COUNT = 64;
endpackage

// File: rtl/permutation_controller.sv
// permutation_controller: sequences load, Count mapper rounds and result handshake for the permutation datapath
module permutation_controller
    import permutation_controller_pkg::*;
#(
    parameter int unsigned Count = DEFAULT_COUNT
) (
    input  logic clk,
    input  logic rst,
    input  logic inValid,
    output logic inReady,
    output logic outValid,
    input  logic outReady,
    output logic busy,
    input  logic cntCo,
    output logic ldReg,
    output logic selRes,
    output logic cntEn,
    output logic cntClr
);
    if (Count < 2) begin : g_bad_count
        $error("permutation_controller: Count must be >= 2");
    end
    state_t state_q, state_d;
    logic in_round, in_done, acc;
    // Output decode and next state; everything is gated by rst so outputs fall asynchronously in reset,
    // and the unused encoding behaves exactly like IDLE
    always_comb begin
        in_round = state_q == S_ROUND;
        in_done  = state_q == S_DONE;
        inReady  = rst & (~(in_round | in_done) | (in_done & outReady));
        acc      = inValid & inReady;
        outValid = rst & in_done;
        busy     = rst & (in_round | in_done);
        ldReg    = acc | (rst & in_round);
        selRes   = rst & in_round;
        cntEn    = rst & in_round;
        cntClr   = acc;
        state_d  = acc ? S_ROUND :
                   in_round ? (cntCo ? S_DONE : S_ROUND) :
                   (in_done & ~outReady) ? S_DONE : S_IDLE;
    end
    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end
endmodule

// File: tb/tb_permutation_controller.sv
// tb_permutation_controller: randomized handshake traffic checked against a job-level timeline model
module tb_permutation_controller;
    localparam int C = 64;
    logic clk = 0, rst, inValid, outReady, cntCo, force_co;
    logic inReady, outValid, busy, ldReg, selRes, cntEn, cntClr;
    logic [6:0] outs;
    int cnt, n_cmp = 0, n_bad = 0, cyc = 0;
    int rounds_done = 0, acc_cyc = 0, rst_hold = 0;
    bit have_job = 0, first_ov = 0, did_rr = 0, did_rd = 0;
    bit e_round, e_done, e_ready, e_acc;
    logic [6:0] e_outs;

    permutation_controller #(.Count(C)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .outValid(outValid), .outReady(outReady), .busy(busy), .cntCo(cntCo),
        .ldReg(ldReg), .selRes(selRes), .cntEn(cntEn), .cntClr(cntClr)
    );

    always #5 clk = ~clk;
    assign outs = {inReady, outValid, busy, ldReg, selRes, cntEn, cntClr};

    // Stand-in for the datapath round counter; force_co injects spurious carries outside rounds
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 0;
        else if (cntClr) cnt <= 0;
        else if (cntEn) cnt <= (cnt == C - 1) ? 0 : cnt + 1;
    end
    assign cntCo = (cnt == C - 1) | force_co;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        rst = 0; inValid = 0; outReady = 0; force_co = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inValid = 1'($urandom_range(0, 1));
            outReady = 1'($urandom_range(0, 1));
            #1 chk("reset", int'(outs), 0);
            @(posedge clk);
        end
        @(negedge clk) rst = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            e_round = have_job && rounds_done < C;
            e_done = have_job && rounds_done == C;
            inValid = (i >= 200 && i < 300) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
            outReady = 1'($urandom_range(0, 1));
            force_co = !e_round && $urandom_range(0, 1) == 1;
            if (rst_hold > 0) rst_hold--;
            else if (!did_rr && e_round && rounds_done == 30) begin did_rr = 1; rst_hold = 2; end
            else if (!did_rd && i > 1500 && e_done && !outReady) begin did_rd = 1; rst_hold = 2; end
            rst = rst_hold == 0;
            #1;
            if (!rst) begin
                have_job = 0;
                first_ov = 0;
                chk("reset_mid", int'(outs), 0);
            end else begin
                e_ready = !have_job || (e_done && outReady);
                e_acc = inValid && e_ready;
                e_outs = {e_ready, e_done, have_job, e_acc | e_round, e_round, e_round, e_acc};
                chk("ctl", int'(outs), int'(e_outs));
                if (outValid && first_ov) begin
                    first_ov = 0;
                    chk("latency", cyc - acc_cyc, C + 1);
                end
            end
            @(posedge clk);
            if (rst) begin
                if (e_acc) begin
                    have_job = 1; rounds_done = 0; acc_cyc = cyc; first_ov = 1;
                end else if (e_round) rounds_done++;
                else if (e_done && outReady) have_job = 0;
            end
            cyc++;
        end
        chk("rst_round_hit", int'(did_rr), 1);
        chk("rst_done_hit", int'(did_rd), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
